led_afterglow: RTL

- Downstream stage of the LED chaser: consumes the 6-bit active-low blade pattern and drives the physical LED pins.
- Each LED that goes dark fades out linearly instead of switching off hard, giving the chaser a comet-tail afterglow.
- Implemented as a per-channel brightness register, a saturating decay on a prescaled tick, and a shared free-running PWM comparator.

---
 rtl/led_afterglow.sv | 73 +++++++
 1 files changed

// File: rtl/led_afterglow.sv
// LED afterglow stage: each dark channel fades out linearly (square-law with LED_AFTERGLOW_GAMMA_EN) under a shared PWM.
// Latency: pattern_in to blade is 2 clk edges. There is no backpressure; the pattern is sampled every cycle.
module led_afterglow #(
  parameter int CHANNELS   = 6,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 16,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] pattern_in,
  output logic [CHANNELS-1:0] blade,
  output logic                glowing
);

  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);
  localparam int                  PS_W    = $clog2(DECAY_DIV);
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(DECAY_DIV - 1);

  logic [CHANNELS-1:0] pattern_q;
  logic [PWM_BITS-1:0] level   [CHANNELS];
  logic [PWM_BITS-1:0] lvl_dec [CHANNELS];
  logic [PWM_BITS-1:0] bright  [CHANNELS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     prescaler;
  logic                decay_tick;
  logic                any_level;
`ifdef LED_AFTERGLOW_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq [CHANNELS];
`endif

  assign decay_tick = (prescaler == PS_LAST);

  always_comb begin
    any_level = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Saturating decrement: levels at or below one step land exactly on zero.
      lvl_dec[i] = (level[i] > STEP) ? (level[i] - STEP) : '0;
`ifdef LED_AFTERGLOW_GAMMA_EN
      sq[i]     = {PWM_BITS'(0), level[i]} * {PWM_BITS'(0), level[i]};
      bright[i] = sq[i][2*PWM_BITS-1:PWM_BITS];
`else
      bright[i] = level[i];
`endif
      any_level = any_level | (level[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      pattern_q <= '1;
      pwm_cnt   <= '0;
      prescaler <= '0;
      blade     <= '1;
      glowing   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) level[i] <= '0;
    end else begin
      pattern_q <= pattern_in;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      prescaler <= decay_tick ? '0 : (prescaler + PS_W'(1));
      glowing   <= (~&pattern_q) | any_level;
      for (int i = 0; i < CHANNELS; i++) begin
        // A lit channel reloads to full even on a decay tick.
        if (!pattern_q[i])   level[i] <= MAX;
        else if (decay_tick) level[i] <= lvl_dec[i];
        blade[i] <= pattern_q[i] ? ~(bright[i] > pwm_cnt) : 1'b0;
      end
    end
  end

endmodule
